// File: rtl/fu_alu_pipe.sv
// Pipelined RV32I integer ALU functional unit with CDB-facing output slot.
// Optional Zba shNadd support is enabled by defining FU_ALU_PIPE_ZBA_EN.
package fu_alu_pipe_pkg;
  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] i_imm;
    logic [31:0] u_imm;
    logic [31:0] pc;
  } decode_info_t;
endpackage

module fu_alu_pipe
  import fu_alu_pipe_pkg::*;
#(
  parameter int PHYS_REG_BITS = 6,
  parameter int ROB_IDX_BITS  = 4,
  parameter int LATENCY       = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     ready,
  input  logic [31:0]              rs1_v,
  input  logic [31:0]              rs2_v,
  input  decode_info_t             decode_info,
  input  logic [PHYS_REG_BITS-1:0] pd_in,
  input  logic [ROB_IDX_BITS-1:0]  rob_idx_in,
  input  logic                     flush,
  input  logic                     cdb_grant,
  output logic                     valid,
  output logic [31:0]              rd_v,
  output logic [PHYS_REG_BITS-1:0] pd_out,
  output logic [ROB_IDX_BITS-1:0]  rob_idx_out,
  output logic                     busy
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [31:0]              rd;
    logic [PHYS_REG_BITS-1:0] pd;
    logic [ROB_IDX_BITS-1:0]  rob;
  } stage_t;

  logic [LATENCY-1:0] val;
  logic [LATENCY-1:0] en;
  stage_t             stg_q  [LATENCY];
  stage_t             stg_in [LATENCY];
  logic [LATENCY-1:0] val_in;
  logic [31:0]        b;
  logic [4:0]         shamt;
  logic [31:0]        alu_res;

  always_comb begin
    b       = (decode_info.opcode == OPC_OP) ? rs2_v : decode_info.i_imm;
    shamt   = b[4:0];
    alu_res = '0;
    case (decode_info.opcode)
      OPC_OP, OPC_OP_IMM: begin
        case (decode_info.funct3)
          3'b000: alu_res = (decode_info.opcode == OPC_OP && decode_info.funct7[5])
                            ? rs1_v - b : rs1_v + b;
          3'b001: alu_res = rs1_v << shamt;
          3'b010: alu_res = {31'b0, ($signed(rs1_v) < $signed(b))};
          3'b011: alu_res = {31'b0, (rs1_v < b)};
          3'b100: alu_res = rs1_v ^ b;
          3'b101: alu_res = decode_info.funct7[5] ? 32'($signed(rs1_v) >>> shamt)
                                                  : rs1_v >> shamt;
          3'b110: alu_res = rs1_v | b;
          default: alu_res = rs1_v & b;
        endcase
`ifdef FU_ALU_PIPE_ZBA_EN
        if (decode_info.opcode == OPC_OP && decode_info.funct7 == 7'b0010000) begin
          case (decode_info.funct3)
            3'b010:  alu_res = (rs1_v << 1) + rs2_v;
            3'b100:  alu_res = (rs1_v << 2) + rs2_v;
            3'b110:  alu_res = (rs1_v << 3) + rs2_v;
            default: ;
          endcase
        end
`else
`endif
      end
      OPC_LUI:   alu_res = decode_info.u_imm;
      OPC_AUIPC: alu_res = decode_info.pc + decode_info.u_imm;
      default:   alu_res = '0;
    endcase
  end

  // A stage may load when it or any stage downstream of it is empty, or the CDB drains the tail.
  always_comb begin
    for (int i = 0; i < LATENCY; i++) begin
      en[i] = cdb_grant;
      for (int j = i; j < LATENCY; j++) begin
        if (!val[j]) en[i] = 1'b1;
      end
    end
  end

  always_comb begin
    stg_in[0] = '{rd: alu_res, pd: pd_in, rob: rob_idx_in};
    val_in    = '0;
    val_in[0] = start;
    for (int i = 1; i < LATENCY; i++) begin
      stg_in[i] = stg_q[i-1];
      val_in[i] = val[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val <= '0;
      for (int i = 0; i < LATENCY; i++) stg_q[i] <= '0;
    end else begin
      for (int i = 0; i < LATENCY; i++) begin
        if (en[i]) begin
          val[i] <= val_in[i] && !flush;
          if (val_in[i]) stg_q[i] <= stg_in[i];
        end else if (flush) begin
          val[i] <= 1'b0;
        end
      end
    end
  end

  assign ready       = en[0];
  assign valid       = val[LATENCY-1];
  assign busy        = |val;
  assign rd_v        = stg_q[LATENCY-1].rd;
  assign pd_out      = stg_q[LATENCY-1].pd;
  assign rob_idx_out = stg_q[LATENCY-1].rob;

endmodule

// File: tb/tb_fu_alu_pipe.sv
// Directed self-checking bench for fu_alu_pipe (LATENCY=2); expectations
// for the Zba encodings follow FU_ALU_PIPE_ZBA_EN.
module tb_fu_alu_pipe;
  import fu_alu_pipe_pkg::*;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         ready;
  logic [31:0]  rs1_v;
  logic [31:0]  rs2_v;
  decode_info_t di;
  logic [5:0]   pd_in;
  logic [3:0]   rob_idx_in;
  logic         flush;
  logic         cdb_grant;
  logic         valid;
  logic [31:0]  rd_v;
  logic [5:0]   pd_out;
  logic [3:0]   rob_idx_out;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;

  fu_alu_pipe #(.PHYS_REG_BITS(6), .ROB_IDX_BITS(4), .LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ready(ready),
    .rs1_v(rs1_v), .rs2_v(rs2_v), .decode_info(di),
    .pd_in(pd_in), .rob_idx_in(rob_idx_in), .flush(flush),
    .cdb_grant(cdb_grant), .valid(valid), .rd_v(rd_v),
    .pd_out(pd_out), .rob_idx_out(rob_idx_out), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] a, input logic [31:0] bv, input logic [31:0] imm,
                        input logic [31:0] u, input logic [31:0] pc,
                        input logic [5:0] pd, input logic [3:0] rob);
    di.opcode  = opc;
    di.funct3  = f3;
    di.funct7  = f7;
    di.i_imm   = imm;
    di.u_imm   = u;
    di.pc      = pc;
    rs1_v      = a;
    rs2_v      = bv;
    pd_in      = pd;
    rob_idx_in = rob;
  endtask

  // Issue the op already set up, wait LATENCY=2 edges, check, then let the CDB take it.
  task automatic exec1(input string tag, input logic [31:0] exp);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq({tag, "_early"}, 32'(valid), 32'd0);
    tick();
    check_eq({tag, "_valid"}, 32'(valid), 32'd1);
    check_eq(tag, rd_v, exp);
    cdb_grant = 1'b1;
    tick();
    cdb_grant = 1'b0;
    check_eq({tag, "_drained"}, 32'(busy), 32'd0);
  endtask

  int seen;

  initial begin
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; cdb_grant = 1'b0;
    set_op(7'd0, 3'd0, 7'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 6'd0, 4'd0);
    #12;
    check_eq("rst_valid", 32'(valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_rd", rd_v, 32'd0);
    check_eq("rst_pd", 32'(pd_out), 32'd0);
    rst_n = 1'b1;
    #1;
    check_eq("rst_ready", 32'(ready), 32'd1);
    tick();

    // addi 5 + -7 with tags
    set_op(OPC_OP_IMM, 3'b000, 7'd0, 32'd5, 32'd0, 32'hFFFF_FFF9, 32'd0, 32'd0, 6'd12, 4'd3);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("addi_early", 32'(valid), 32'd0);
    tick();
    check_eq("addi_valid", 32'(valid), 32'd1);
    check_eq("addi_rd", rd_v, 32'hFFFF_FFFE);
    check_eq("addi_pd", 32'(pd_out), 32'd12);
    check_eq("addi_rob", 32'(rob_idx_out), 32'd3);
    cdb_grant = 1'b1;
    tick();
    cdb_grant = 1'b0;
    check_eq("addi_consumed", 32'(valid), 32'd0);

    set_op(OPC_OP, 3'b101, 7'b0100000, 32'h8000_0000, 32'h24, 32'd0, 32'd0, 32'd0, 6'd1, 4'd1);
    exec1("sra", 32'hF800_0000);
    set_op(OPC_OP, 3'b101, 7'b0000000, 32'h8000_0000, 32'h24, 32'd0, 32'd0, 32'd0, 6'd1, 4'd1);
    exec1("srl", 32'h0800_0000);
    set_op(OPC_OP, 3'b010, 7'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd0, 6'd1, 4'd1);
    exec1("slt", 32'd1);
    set_op(OPC_OP, 3'b011, 7'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd0, 6'd1, 4'd1);
    exec1("sltu", 32'd0);
    set_op(OPC_AUIPC, 3'd0, 7'd0, 32'd0, 32'd0, 32'd0, 32'h2000, 32'h1000, 6'd1, 4'd1);
    exec1("auipc", 32'h3000);
    set_op(OPC_LUI, 3'd0, 7'd0, 32'd0, 32'd0, 32'd0, 32'hABCD_E000, 32'h44, 6'd1, 4'd1);
    exec1("lui", 32'hABCD_E000);
    set_op(OPC_OP, 3'b000, 7'b0100000, 32'd5, 32'd7, 32'd0, 32'd0, 32'd0, 6'd1, 4'd1);
    exec1("sub", 32'hFFFF_FFFE);
    set_op(OPC_OP_IMM, 3'b001, 7'd0, 32'h0000_0003, 32'd0, 32'd4, 32'd0, 32'd0, 6'd1, 4'd1);
    exec1("slli", 32'h30);
    set_op(7'b1100011, 3'd0, 7'd0, 32'd9, 32'd9, 32'd9, 32'd9, 32'd9, 6'd1, 4'd1);
    exec1("other_opc", 32'd0);

    // back-to-back issue with CDB blocked: only two ops fit
    for (int k = 0; k < 4; k++) begin
      set_op(OPC_OP, 3'b000, 7'd0, 32'(100 * (k + 1)), 32'd1, 32'd0, 32'd0, 32'd0, 6'(k), 4'(k));
      start = 1'b1;
      #0;
      check_eq($sformatf("b2b_ready%0d", k), 32'(ready), (k < 2) ? 32'd1 : 32'd0);
      tick();
    end
    start = 1'b0;
    check_eq("full_valid", 32'(valid), 32'd1);
    check_eq("full_busy", 32'(busy), 32'd1);
    check_eq("full_hold_pd", 32'(pd_out), 32'd0);
    check_eq("full_hold_rd", rd_v, 32'd101);

    // drain with grant every cycle while issuing ops 2 and 3
    cdb_grant = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c < 2) begin
        set_op(OPC_OP, 3'b000, 7'd0, 32'(100 * (c + 3)), 32'd1, 32'd0, 32'd0, 32'd0, 6'(c + 2), 4'(c + 2));
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      #0;
      check_eq($sformatf("drain_valid%0d", c), 32'(valid), 32'd1);
      check_eq($sformatf("drain_pd%0d", c), 32'(pd_out), 32'(c));
      check_eq($sformatf("drain_rd%0d", c), rd_v, 32'(100 * (c + 1) + 1));
      tick();
    end
    start = 1'b0;
    cdb_grant = 1'b0;
    check_eq("drain_empty", 32'(valid), 32'd0);
    check_eq("drain_busy", 32'(busy), 32'd0);

    // flush with two in flight plus a same-cycle start
    set_op(OPC_OP, 3'b000, 7'd0, 32'd1, 32'd1, 32'd0, 32'd0, 32'd0, 6'd7, 4'd7);
    start = 1'b1;
    tick();
    tick();
    check_eq("preflush_valid", 32'(valid), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    start = 1'b0;
    check_eq("flush_valid", 32'(valid), 32'd0);
    check_eq("flush_busy", 32'(busy), 32'd0);
    cdb_grant = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (valid) seen++;
      tick();
    end
    cdb_grant = 1'b0;
    check_eq("flush_no_result", 32'(seen), 32'd0);

    // async reset while stalled with a valid result
    set_op(OPC_OP, 3'b110, 7'd0, 32'hF0, 32'h0F, 32'd0, 32'd0, 32'd0, 6'd9, 4'd9);
    start = 1'b1;
    tick();
    tick();
    start = 1'b0;
    check_eq("prerst_valid", 32'(valid), 32'd1);
    check_eq("prerst_rd", rd_v, 32'hFF);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_valid", 32'(valid), 32'd0);
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_rd", rd_v, 32'd0);
    check_eq("arst_pd", 32'(pd_out), 32'd0);
    check_eq("arst_rob", 32'(rob_idx_out), 32'd0);
    #2 rst_n = 1'b1;
    #1;
    check_eq("arst_ready", 32'(ready), 32'd1);
    tick();
    set_op(OPC_OP, 3'b000, 7'd0, 32'd1, 32'd1, 32'd0, 32'd0, 32'd0, 6'd2, 4'd2);
    exec1("post_rst_add", 32'd2);

    // Zba encodings
    set_op(OPC_OP, 3'b010, 7'b0010000, 32'd3, 32'd10, 32'd0, 32'd0, 32'd0, 6'd3, 4'd3);
`ifdef FU_ALU_PIPE_ZBA_EN
    exec1("sh1add", 32'd16);
`else
    exec1("sh1add_as_slt", 32'd1);
`endif
    set_op(OPC_OP, 3'b100, 7'b0010000, 32'd3, 32'd10, 32'd0, 32'd0, 32'd0, 6'd3, 4'd3);
`ifdef FU_ALU_PIPE_ZBA_EN
    exec1("sh2add", 32'd22);
`else
    exec1("sh2add_as_xor", 32'd9);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
